// File: rtl/noc_out_port_arbiter_pkg.sv
// rtl/noc_out_port_arbiter_pkg.sv - shared types and constants for the NoC output port arbiter
// Contents: flit type codes, scheduler state encoding, default sizes,
//           and helpers for locating and decoding the flit type field.
package noc_pkg;

  localparam int NOC_NUM_PORTS = 5;
  localparam int NOC_FLIT_W    = 40;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    SEND = 2'd3
  } state_e;

  // The type field occupies the two most significant bits of a flit.
  function automatic int type_lsb(input int flit_w);
    return flit_w - 2;
  endfunction

  // TAIL and SINGLE are the flits that release a wormhole lock.
  function automatic logic ends_packet(input logic [1:0] ftype);
    return (ftype == FLIT_TAIL) || (ftype == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/noc_out_port_arbiter_if.sv
// rtl/noc_out_port_arbiter_if.sv - FIFO-side and link-side signal bundle of one output port
// Signals: fifo_empty/fifo_wr/fifo_dout from the input FIFOs, fifo_rd back to them,
//          out_flit/out_valid/out_ready towards the link, grant/busy status.
// Modports: master = the arbiter, slave = the FIFOs and link around it.
interface noc_out_port_arbiter_if
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = NOC_NUM_PORTS,
  parameter int FLIT_W    = NOC_FLIT_W
) ();

  logic [NUM_PORTS-1:0]        fifo_empty;
  logic [NUM_PORTS-1:0]        fifo_wr;
  logic [NUM_PORTS*FLIT_W-1:0] fifo_dout;
  logic [NUM_PORTS-1:0]        fifo_rd;
  logic [FLIT_W-1:0]           out_flit;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_PORTS-1:0]        grant;
  logic                        busy;

  modport master (
    input  fifo_empty, fifo_wr, fifo_dout, out_ready,
    output fifo_rd, out_flit, out_valid, grant, busy
  );

  modport slave (
    output fifo_empty, fifo_wr, fifo_dout, out_ready,
    input  fifo_rd, out_flit, out_valid, grant, busy
  );

endinterface

// File: rtl/noc_out_port_arbiter_rr_arbiter.sv
// rtl/noc_out_port_arbiter_rr_arbiter.sv - combinational round-robin picker
// Ports: req  - request vector
//        ptr  - index of the last winner; search starts at ptr+1 and wraps
//        gnt  - one-hot winner (0 when no request)
//        idx  - winner index
//        any  - at least one request present
module rr_arbiter #(
  parameter int NUM_PORTS = 5,
  parameter int PTR_W     = 3
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PTR_W-1:0]     idx,
  output logic                 any
);

  // Two ordered passes: indices above ptr first, then 0..ptr, which is the
  // ptr+1, ptr+2, ... wrap-around order without variable-index arithmetic.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!any && req[j] && (PTR_W'(j) > ptr)) begin
        gnt[j] = 1'b1;
        idx    = PTR_W'(j);
        any    = 1'b1;
      end
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!any && req[j] && (PTR_W'(j) <= ptr)) begin
        gnt[j] = 1'b1;
        idx    = PTR_W'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_out_port_arbiter.sv
// rtl/noc_out_port_arbiter.sv - wormhole round-robin scheduler for one router output link
// Ports: clk - rising-edge clock
//        rst - asynchronous active-high reset
//        bus - master side of noc_out_port_arbiter_if (FIFO status/data in,
//              fifo_rd out, out_flit/out_valid/out_ready link handshake, grant/busy)
module noc_out_port_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = NOC_NUM_PORTS,
  parameter int FLIT_W    = NOC_FLIT_W,
  parameter int PTR_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  noc_out_port_arbiter_if.master bus
);

  localparam int TYPE_LSB = type_lsb(FLIT_W);

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 busy_q, busy_d;
  logic                 out_valid_q, out_valid_d;
  logic [FLIT_W-1:0]    out_flit_q, out_flit_d;
  logic [NUM_PORTS-1:0] fifo_rd_c;

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] arb_gnt;
  logic [PTR_W-1:0]     arb_idx;
  logic                 arb_any;

  // A read in the same cycle as a write is dropped by the FIFO, so a port
  // being written is treated as not ready.
  assign eligible = ~bus.fifo_empty & ~bus.fifo_wr;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_rr_arbiter (
    .req (eligible),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    fifo_rd_c   = '0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d  = arb_gnt;
          rr_ptr_d = arb_idx;
          busy_d   = 1'b1;
          state_d  = READ;
        end
      end
      READ: begin
        // Stall here with the lock held until the owner can be read again.
        if (|(grant_q & eligible)) begin
          fifo_rd_c = grant_q;
          state_d   = CAPT;
        end
      end
      CAPT: begin
        // rr_ptr_q holds the owner's index for the whole lock.
        out_flit_d  = bus.fifo_dout[int'(rr_ptr_q)*FLIT_W +: FLIT_W];
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (ends_packet(out_flit_q[TYPE_LSB +: 2])) begin
            grant_d = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= PTR_W'(NUM_PORTS - 1);
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
    end
  end

  assign bus.fifo_rd   = fifo_rd_c;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_flit  = out_flit_q;

endmodule

// File: doc/noc_out_port_arbiter.md
Name: noc_out_port_arbiter

Overview:
- Output-port scheduler for one router output link.
- Shares the link among NUM_PORTS input flit FIFOs (N, E, S, W, Local) by round-robin arbitration, with the grant locked for a whole packet (wormhole).
- Sequences FIFO reads: pulses the read strobe, captures the registered FIFO output one cycle later, and presents the flit on a valid/ready output.

Parameters:
- NUM_PORTS, 5, number of input FIFOs arbitrated.
- FLIT_W, 40, flit width in bits; must equal the FIFO data width.
- PTR_W, 3, width of the round-robin pointer; must satisfy 2^PTR_W >= NUM_PORTS.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  NUM_PORTS  per-FIFO empty flag.
- fifo_wr  input  NUM_PORTS  per-FIFO write strobe, monitored only.
- fifo_dout  input  NUM_PORTS*FLIT_W  packed FIFO data outputs; port i occupies bits [i*FLIT_W +: FLIT_W].
- fifo_rd  output  NUM_PORTS  one-hot read strobe to the FIFOs.
- out_flit  output  FLIT_W  flit presented to the link.
- out_valid  output  1  out_flit is valid.
- out_ready  input  1  downstream accepts the flit.
- grant  output  NUM_PORTS  one-hot current owner; 0 when unlocked.
- busy  output  1  a packet lock is held.

Behaviour:
- Flit type field is out_flit[FLIT_W-1:FLIT_W-2]: 01 HEAD, 00 BODY, 10 TAIL, 11 SINGLE.
- Port i is eligible when fifo_empty[i]=0 and fifo_wr[i]=0. The FIFO silently drops a read issued in the same cycle as a write, so fifo_rd[i] is never asserted while fifo_wr[i]=1.
- Reset values: all outputs 0, state IDLE, rr_ptr = NUM_PORTS-1 (port 0 has first priority).
- IDLE:
  - If any port is eligible, pick the first eligible port searching rr_ptr+1, rr_ptr+2, ... with wrap at NUM_PORTS.
  - Set grant and busy, update rr_ptr to the winner, and go to READ in the same cycle.
  - The winner's fifo_rd is asserted during READ, not in IDLE.
- READ:
  - If the granted port is eligible: fifo_rd[g]=1 for exactly one cycle, then go to CAPT.
  - Otherwise (mid-packet underflow or write collision): fifo_rd stays 0 and the state stays READ; the lock is held and no other port is served.
- CAPT: out_flit <= fifo_dout[g] (the FIFO data is registered and valid this cycle); out_valid <= 1; go to SEND.
- SEND:
  - Hold out_flit and out_valid until out_ready=1.
  - On the accept cycle (out_valid & out_ready), out_valid <= 0.
  - If the accepted flit type is TAIL or SINGLE: clear grant and busy, go to IDLE.
  - Otherwise go to READ on the same port.
- Timing: HEAD from IDLE reaches out_valid 3 cycles after the eligible request. Steady-state throughput is 1 flit per 3 cycles with out_ready held high.
- out_flit is not cleared on accept; it keeps its last value while out_valid=0.
- BODY or TAIL flits arriving without a preceding HEAD are forwarded unchanged; no checking is performed.
- rst asserted mid-packet: immediate return to reset values. The partially sent packet is abandoned and nothing already read from the FIFO is replayed.
- Only one grant, one fifo_rd bit, and one flit are in flight at a time. fifo_rd is always a subset of grant.

Decomposition:
- Package noc_pkg:
  - flit type constants FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE;
  - type field position derived from FLIT_W;
  - state encoding IDLE, READ, CAPT, SEND;
  - default port count 5.
- Sub-module rr_arbiter: combinational round-robin pick from request vector and rr_ptr, returning a one-hot grant and its index. It is reused later for the crossbar's per-output arbiters.

Test Plan:
- Single SINGLE flit on port 2 (empty[2] drops at t0) -> fifo_rd=00100 at t0+1; out_valid with the flit at t0+3; grant=0 and busy=0 after accept.
- Ports 0, 1, and 3 each hold one SINGLE flit simultaneously, out_ready=1 -> service order 0, 1, 3, then back to 0 on the next request; rr_ptr=3 afterwards.
- Port 1 sends HEAD, BODY, BODY, TAIL while port 4 requests throughout -> all four port-1 flits go out contiguously before any port-4 flit; grant stays 00010 until the TAIL is accepted.
- out_ready held low 5 cycles in SEND -> out_flit stable, no further fifo_rd pulses; accept on cycle 6 then proceeds.
- Port 0 mid-packet goes empty for 4 cycles, then fifo_wr[0]=1 for one cycle -> no fifo_rd during empty or write cycles, lock held, port 2 requests ignored; read resumes the cycle after the write.
- rst pulsed during SEND of a BODY flit -> out_valid, grant, busy, and fifo_rd all 0 asynchronously; next arbitration starts from port 0 priority.
